// File: rtl/pmu_i2c_target_pkg.sv
// pmu_i2c_target_pkg: bus address and FSM encodings shared by the PMU I2C target and its benches.
package pmu_i2c_target_pkg;
  localparam logic [6:0] PMU_I2C_ADDR7 = 7'h34;
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR    = 4'd1,
    ST_SUB     = 4'd2,
    ST_WR_DATA = 4'd3,
    ST_RD_DATA = 4'd4,
    ST_IGNORE  = 4'd5
  } state_e;
endpackage

// File: rtl/pmu_i2c_target_line_filter.sv
// pmu_i2c_target_line_filter: 2-flop sync plus stability filter with registered rise/fall pulses.
module pmu_i2c_target_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic level_q, rise_q, fall_q, diff, take;
  assign diff = sync_q[1] != level_q;
  assign take = diff && cnt_q == CW'(FILTER_LEN - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      cnt_q   <= (diff && !take) ? cnt_q + CW'(1) : '0;
      level_q <= take ? sync_q[1] : level_q;
      rise_q  <= take && sync_q[1];
      fall_q  <= take && !sync_q[1];
    end
  end
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/pmu_i2c_target.sv
// pmu_i2c_target: I2C target modelling the PMU register file, with write strobe and host read port.
module pmu_i2c_target
  import pmu_i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = PMU_I2C_ADDR7,
  parameter int         REG_AW     = 6,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire               scl,
  inout  wire               sda,
  input  logic [REG_AW-1:0] reg_rd_addr,
  output logic [7:0]        reg_rd_data,
  output logic              wr_valid,
  output logic [7:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic [7:0]        debug
);
  state_e state_q, state_d;
  logic [3:0] bit_q;
  logic [7:0] shift_q, tx_q, ptr_q, wr_addr_q, wr_data_q, byte_in, rd_byte;
  logic [7:0] regs_q [2**REG_AW];
  logic drv_q, mack_q, busy_q, wr_valid_q, sda_pull;
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, done8, ack_fall, end_fall, addr_ok;

  pmu_i2c_target_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .reset(reset), .line_i(scl), .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  pmu_i2c_target_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .reset(reset), .line_i(sda), .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  // bit_q counts SCL rises in a frame: 1..8 data bits, 9 the ACK clock
  assign start    = sda_fall && scl_lvl;
  assign stop     = sda_rise && scl_lvl;
  assign byte_in  = {shift_q[6:0], sda_lvl};
  assign done8    = scl_rise && bit_q == 4'd7;
  assign ack_fall = scl_fall && bit_q == 4'd8;
  assign end_fall = scl_fall && bit_q == 4'd9;
  assign addr_ok  = shift_q[7:1] == DEV_ADDR;
  assign rd_byte  = regs_q[ptr_q[REG_AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) state_d = ST_ADDR;
    else if (stop) state_d = ST_IDLE;
    else if (end_fall && state_q == ST_ADDR) state_d = !addr_ok ? ST_IGNORE : shift_q[0] ? ST_RD_DATA : ST_SUB;
    else if (end_fall && state_q == ST_SUB) state_d = ST_WR_DATA;
    else if (end_fall && state_q == ST_RD_DATA) state_d = mack_q ? ST_RD_DATA : ST_IGNORE;
  end

  always_comb begin
    sda_pull = drv_q && !reset;
    debug    = {4'd0, state_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      drv_q      <= 1'b0;
      mack_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < 2**REG_AW; i++) regs_q[i] <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start) begin
        bit_q <= '0;
        drv_q <= 1'b0;
      end else if (stop) begin
        drv_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        if (scl_rise && bit_q != 4'd9) bit_q <= bit_q + 4'd1;
        if (scl_rise && bit_q < 4'd8) shift_q <= byte_in;
        if (done8 && state_q == ST_ADDR) busy_q <= byte_in[7:1] == DEV_ADDR;
        if (done8 && state_q == ST_SUB) ptr_q <= byte_in;
        if (done8 && state_q == ST_WR_DATA) begin
          regs_q[ptr_q[REG_AW-1:0]] <= byte_in;
          wr_valid_q <= 1'b1;
          wr_addr_q  <= ptr_q;
          wr_data_q  <= byte_in;
          ptr_q      <= ptr_q + 8'd1;
        end
        if (scl_rise && bit_q == 4'd8 && state_q == ST_RD_DATA) begin
          mack_q <= !sda_lvl;
          ptr_q  <= ptr_q + 8'd1;
        end
        if (ack_fall) drv_q <= state_q == ST_SUB || state_q == ST_WR_DATA || (state_q == ST_ADDR && addr_ok);
        if (scl_fall && state_q == ST_RD_DATA && bit_q inside {[4'd1:4'd7]}) begin
          tx_q  <= tx_q << 1;
          drv_q <= !tx_q[6];
        end
        if (end_fall) begin
          bit_q <= '0;
          tx_q  <= rd_byte;
          drv_q <= state_d == ST_RD_DATA && !rd_byte[7];
        end
      end
    end
  end

  assign sda         = sda_pull ? 1'b0 : 1'bz;
  assign reg_rd_data = regs_q[reg_rd_addr];
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
endmodule
